lcd_screen_writer: RTL

- HD44780 16x2 character-LCD sequencer that consumes the delayed LCD-reset level from the reset-delay stage as its "panel ready" input.
- When ready goes high, it runs the controller init sequence, then writes a 32-character screen fetched from the voting-terminal text buffer.
- It generates LCD_EN/RS/DATA bus timing directly and drives the LCD pins on the board.
- It supports software refresh requests, which rewrite the screen without re-running init.

---
 rtl/lcd_screen_writer_pkg.sv | 43 ++++
 rtl/lcd_screen_writer_strobe.sv | 88 ++++++++
 rtl/lcd_screen_writer.sv | 135 +++++++++++++
 3 files changed

// File: rtl/lcd_screen_writer_pkg.sv
// Shared types, HD44780 command bytes and step-list helpers for the LCD screen writer.
// The 38-step list: 4 init commands, line-1 address, 16 chars, line-2 address, 16 chars.
package lcd_pkg;

  typedef enum logic [1:0] {ST_WAIT_READY, ST_LOAD, ST_XFER, ST_IDLE} state_e;
  typedef enum logic [2:0] {PH_IDLE, PH_SETUP, PH_PULSE, PH_HOLD, PH_WAIT} phase_e;

  localparam logic [7:0] LCD_FUNC_SET = 8'h38;
  localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
  localparam logic [7:0] LCD_CLEAR    = 8'h01;
  localparam logic [7:0] LCD_ENTRY    = 8'h06;
  localparam logic [7:0] LCD_LINE1    = 8'h80;
  localparam logic [7:0] LCD_LINE2    = 8'hC0;

  localparam logic [5:0] REFRESH_STEP = 6'd4;
  localparam logic [5:0] LINE2_STEP   = 6'd21;
  localparam logic [5:0] LAST_STEP    = 6'd37;

  function automatic logic step_is_char(input logic [5:0] step);
    return ((step > REFRESH_STEP) && (step < LINE2_STEP)) || (step > LINE2_STEP);
  endfunction

  function automatic logic [4:0] step_addr(input logic [5:0] step);
    return (step > LINE2_STEP) ? 5'(step - 6'd6) : 5'(step - 6'd5);
  endfunction

  function automatic logic [7:0] step_cmd(input logic [5:0] step);
    case (step)
      6'd0:    return LCD_FUNC_SET;
      6'd1:    return LCD_DISP_ON;
      6'd2:    return LCD_CLEAR;
      6'd3:    return LCD_ENTRY;
      6'd4:    return LCD_LINE1;
      default: return LCD_LINE2;
    endcase
  endfunction

  // Control codes and DEL would be interpreted by the panel; show them as blanks.
  function automatic logic [7:0] char_filter(input logic [7:0] c);
    return ((c < 8'h20) || (c == 8'h7F)) ? 8'h20 : c;
  endfunction

endpackage

// File: rtl/lcd_screen_writer_strobe.sv
// One-byte LCD bus transfer: SETUP, EN pulse, HOLD, then the controller execution wait.
// done_o is high in the last WAIT cycle so the caller can chain the next byte without a gap.
module lcd_bus_strobe
  import lcd_pkg::*;
#(
  parameter int unsigned EN_HIGH_CYC   = 16,
  parameter int unsigned SETUP_CYC     = 4,
  parameter int unsigned CMD_WAIT_CYC  = 100000,
  parameter int unsigned CHAR_WAIT_CYC = 2500
) (
  input  logic iCLK,
  input  logic FORCE_RESET,
  input  logic start_i,
  input  logic abort_i,
  input  logic long_wait_i,
  output logic en_o,
  output logic done_o
);

  localparam int unsigned MAX_A   = (EN_HIGH_CYC > SETUP_CYC) ? EN_HIGH_CYC : SETUP_CYC;
  localparam int unsigned MAX_B   = (CMD_WAIT_CYC > CHAR_WAIT_CYC) ? CMD_WAIT_CYC : CHAR_WAIT_CYC;
  localparam int unsigned MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  phase_e             phase_q, phase_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               long_q, long_d;
  logic               en_q, en_d;

  function automatic logic [CNT_W-1:0] reload(input int unsigned n);
    return CNT_W'(n - 1);
  endfunction

  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    long_d  = long_q;
    done_o  = 1'b0;
    if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
    case (phase_q)
      PH_IDLE: if (start_i) begin
        phase_d = PH_SETUP;
        cnt_d   = reload(SETUP_CYC);
        long_d  = long_wait_i;
      end
      PH_SETUP: if (cnt_q == '0) begin
        phase_d = PH_PULSE;
        cnt_d   = reload(EN_HIGH_CYC);
      end
      PH_PULSE: if (cnt_q == '0) begin
        phase_d = PH_HOLD;
        cnt_d   = reload(SETUP_CYC);
      end
      PH_HOLD: if (cnt_q == '0) begin
        phase_d = PH_WAIT;
        cnt_d   = long_q ? reload(CMD_WAIT_CYC) : reload(CHAR_WAIT_CYC);
      end
      PH_WAIT: if (cnt_q == '0) begin
        phase_d = PH_IDLE;
        done_o  = 1'b1;
      end
      default: phase_d = PH_IDLE;
    endcase
    if (abort_i) begin
      phase_d = PH_IDLE;
      cnt_d   = '0;
      done_o  = 1'b0;
    end
    en_d = (phase_d == PH_PULSE);
  end

  always_ff @(posedge iCLK or negedge FORCE_RESET) begin
    if (!FORCE_RESET) begin
      phase_q <= PH_IDLE;
      cnt_q   <= '0;
      long_q  <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      long_q  <= long_d;
      en_q    <= en_d;
    end
  end

  assign en_o = en_q;

endmodule

// File: rtl/lcd_screen_writer.sv
// HD44780 16x2 sequencer: init on panel-ready, then 32 chars from the text buffer; refresh skips init.
// Dropping iREADY aborts at the next edge; LCD_DATA/RS only change in the second LOAD cycle.
module lcd_screen_writer
  import lcd_pkg::*;
#(
  parameter int unsigned EN_HIGH_CYC   = 16,
  parameter int unsigned SETUP_CYC     = 4,
  parameter int unsigned CMD_WAIT_CYC  = 100000,
  parameter int unsigned CHAR_WAIT_CYC = 2500
) (
  input  logic       iCLK,
  input  logic       FORCE_RESET,
  input  logic       iREADY,
  input  logic       iREFRESH,
  output logic [4:0] oCHAR_ADDR,
  input  logic [7:0] iCHAR_DATA,
  output logic [7:0] LCD_DATA,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_EN,
  output logic       oBUSY,
  output logic       oDONE
);

  state_e      state_q, state_d;
  logic [5:0]  step_q, step_d;
  logic        load_ph_q, load_ph_d;
  logic [7:0]  data_q, data_d;
  logic        rs_q, rs_d;
  logic [4:0]  addr_q, addr_d;
  logic        pending_q, pending_d;
  logic        start, abort, long_wait, xfer_done;
  logic [7:0]  load_byte;

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    load_ph_d = load_ph_q;
    data_d    = data_q;
    rs_d      = rs_q;
    addr_d    = addr_q;
    pending_d = pending_q;
    start     = 1'b0;
    abort     = 1'b0;
    long_wait = 1'b0;
    load_byte = step_is_char(step_q) ? char_filter(iCHAR_DATA) : step_cmd(step_q);
    case (state_q)
      ST_WAIT_READY: if (iREADY) begin
        step_d    = '0;
        state_d   = ST_LOAD;
        load_ph_d = 1'b0;
      end
      ST_LOAD: if (!load_ph_q) begin
        load_ph_d = 1'b1;
      end else begin
        data_d    = load_byte;
        rs_d      = step_is_char(step_q);
        long_wait = (load_byte == LCD_CLEAR);
        start     = 1'b1;
        state_d   = ST_XFER;
      end
      ST_XFER: if (xfer_done) begin
        if (step_q == LAST_STEP) begin
          state_d = ST_IDLE;
        end else begin
          step_d    = step_q + 6'd1;
          state_d   = ST_LOAD;
          load_ph_d = 1'b0;
        end
      end
      ST_IDLE: if (pending_q || iREFRESH) begin
        pending_d = 1'b0;
        step_d    = REFRESH_STEP;
        state_d   = ST_LOAD;
        load_ph_d = 1'b0;
      end
      default: state_d = ST_WAIT_READY;
    endcase
    if (iREFRESH && (state_q != ST_IDLE) && (state_q != ST_WAIT_READY)) pending_d = 1'b1;
    // Abort overrides everything, including a refresh arriving in the same cycle.
    if (!iREADY && (state_q != ST_WAIT_READY)) begin
      state_d   = ST_WAIT_READY;
      step_d    = '0;
      load_ph_d = 1'b0;
      pending_d = 1'b0;
      start     = 1'b0;
      abort     = 1'b1;
    end
    // Address is presented in LOAD cycle 1 so buffer data lands in cycle 2.
    if ((state_d == ST_LOAD) && !load_ph_d && step_is_char(step_d)) addr_d = step_addr(step_d);
  end

  always_ff @(posedge iCLK or negedge FORCE_RESET) begin
    if (!FORCE_RESET) begin
      state_q   <= ST_WAIT_READY;
      step_q    <= '0;
      load_ph_q <= 1'b0;
      data_q    <= '0;
      rs_q      <= 1'b0;
      addr_q    <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      load_ph_q <= load_ph_d;
      data_q    <= data_d;
      rs_q      <= rs_d;
      addr_q    <= addr_d;
      pending_q <= pending_d;
    end
  end

  lcd_bus_strobe #(
    .EN_HIGH_CYC  (EN_HIGH_CYC),
    .SETUP_CYC    (SETUP_CYC),
    .CMD_WAIT_CYC (CMD_WAIT_CYC),
    .CHAR_WAIT_CYC(CHAR_WAIT_CYC)
  ) u_strobe (
    .iCLK       (iCLK),
    .FORCE_RESET(FORCE_RESET),
    .start_i    (start),
    .abort_i    (abort),
    .long_wait_i(long_wait),
    .en_o       (LCD_EN),
    .done_o     (xfer_done)
  );

  assign oCHAR_ADDR = addr_q;
  assign LCD_DATA   = data_q;
  assign LCD_RS     = rs_q;
  assign LCD_RW     = 1'b0;
  assign oBUSY      = (state_q != ST_IDLE);
  assign oDONE      = (state_q == ST_IDLE);

endmodule
